// File: rtl/beam_scan_controller_if.sv
// rtl/beam_scan_controller_if.sv - control/data/status bundle between scan controller and its host
interface beam_scan_controller_if #(
    parameter int DATA_W = 22,
    parameter int ACC_W  = 27
);
    logic                     start;
    logic                     manual_en;
    logic [4:0]               manual_delay;
    logic signed [DATA_W-1:0] sum_in;
    logic [4:0]               delay_select;
    logic [4:0]               best_delay;
    logic [ACC_W-1:0]         best_energy;
    logic                     busy;
    logic                     done;

    modport master (
        output start, manual_en, manual_delay, sum_in,
        input  delay_select, best_delay, best_energy, busy, done
    );

    modport slave (
        input  start, manual_en, manual_delay, sum_in,
        output delay_select, best_delay, best_energy, busy, done
    );
endinterface

// File: rtl/beam_scan_controller.sv
// rtl/beam_scan_controller.sv - sweeps beams, measures per-beam energy, locks onto the loudest
module beam_scan_controller #(
    parameter int NUM_BEAMS     = 32,
    parameter int SETTLE_FRAMES = 8,
    parameter int MEAS_LOG2     = 6,
    parameter int DATA_W        = 22
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lr_clk,
    beam_scan_controller_if.slave bus
);
    localparam int ACC_W   = DATA_W - 1 + MEAS_LOG2;
    localparam int SET_W   = $clog2(SETTLE_FRAMES + 1);
    localparam int CNT_W   = (MEAS_LOG2 + 1 > SET_W) ? MEAS_LOG2 + 1 : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'((1 << MEAS_LOG2) - 1);
    localparam logic [4:0]       LAST_BEAM   = 5'(NUM_BEAMS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_COMPARE, S_LOCK} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_lr_sync;
    logic             w_fs;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]       r_beam, w_beam_nxt;
    logic [4:0]       r_delay, w_delay_nxt;
    logic [4:0]       r_run_delay, w_run_delay_nxt;
    logic [4:0]       r_best_delay, w_best_delay_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [ACC_W-1:0] r_run_energy, w_run_energy_nxt;
    logic [ACC_W-1:0] r_best_energy, w_best_energy_nxt;
    logic             r_done, w_done_nxt;
    logic [DATA_W-1:0] w_neg;
    logic [DATA_W-2:0] w_abs;
    logic              w_take;

    // Two flops for metastability, the third only for edge detection.
    assign w_fs = r_lr_sync[1] & ~r_lr_sync[2];

    assign w_neg = -bus.sum_in;
    always_comb begin
        w_abs = bus.sum_in[DATA_W-2:0];
        if (bus.sum_in[DATA_W-1]) begin
            if (bus.sum_in[DATA_W-2:0] == '0) w_abs = '1;
            else                              w_abs = w_neg[DATA_W-2:0];
        end
    end

    // Running best is kept apart so an aborted scan never disturbs the published result.
    assign w_take = (r_beam == 5'd0) || (r_acc > r_run_energy);

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_beam_nxt        = r_beam;
        w_delay_nxt       = r_delay;
        w_run_delay_nxt   = r_run_delay;
        w_run_energy_nxt  = r_run_energy;
        w_best_delay_nxt  = r_best_delay;
        w_best_energy_nxt = r_best_energy;
        w_acc_nxt         = r_acc;
        w_done_nxt        = 1'b0;
        if (bus.manual_en) begin
            w_state_nxt = S_IDLE;
            w_delay_nxt = bus.manual_delay;
        end else begin
            case (r_state)
                S_IDLE, S_LOCK: begin
                    if (bus.start) begin
                        w_state_nxt = S_SETTLE;
                        w_beam_nxt  = 5'd0;
                        w_delay_nxt = 5'd0;
                        w_cnt_nxt   = '0;
                    end
                end
                S_SETTLE: begin
                    if (w_fs) begin
                        if (r_cnt == SETTLE_LAST) begin
                            w_state_nxt = S_MEASURE;
                            w_cnt_nxt   = '0;
                            w_acc_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (w_fs) begin
                        w_acc_nxt = r_acc + ACC_W'(w_abs);
                        if (r_cnt == MEAS_LAST) begin
                            w_state_nxt = S_COMPARE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                S_COMPARE: begin
                    if (w_take) begin
                        w_run_delay_nxt  = r_beam;
                        w_run_energy_nxt = r_acc;
                    end
                    if (r_beam == LAST_BEAM) begin
                        w_state_nxt       = S_LOCK;
                        w_done_nxt        = 1'b1;
                        w_delay_nxt       = w_run_delay_nxt;
                        w_best_delay_nxt  = w_run_delay_nxt;
                        w_best_energy_nxt = w_run_energy_nxt;
                    end else begin
                        w_state_nxt = S_SETTLE;
                        w_beam_nxt  = r_beam + 5'd1;
                        w_delay_nxt = r_beam + 5'd1;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_lr_sync     <= '0;
            r_cnt         <= '0;
            r_beam        <= '0;
            r_delay       <= '0;
            r_run_delay   <= '0;
            r_run_energy  <= '0;
            r_best_delay  <= '0;
            r_best_energy <= '0;
            r_acc         <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lr_sync     <= {r_lr_sync[1:0], i_lr_clk};
            r_cnt         <= w_cnt_nxt;
            r_beam        <= w_beam_nxt;
            r_delay       <= w_delay_nxt;
            r_run_delay   <= w_run_delay_nxt;
            r_run_energy  <= w_run_energy_nxt;
            r_best_delay  <= w_best_delay_nxt;
            r_best_energy <= w_best_energy_nxt;
            r_acc         <= w_acc_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign bus.delay_select = r_delay;
    assign bus.best_delay   = r_best_delay;
    assign bus.best_energy  = r_best_energy;
    assign bus.done         = r_done;
    assign bus.busy         = (r_state == S_SETTLE) || (r_state == S_MEASURE) ||
                              (r_state == S_COMPARE);
endmodule
